// File: rtl/sync_event_arbiter_pkg.sv
// Shared types and helpers for the synchronized-event arbiter.
package sync_evt_pkg;

  typedef enum logic {S_IDLE, S_OFFER} sync_evt_state_t;

  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_event_arbiter_if.sv
// Valid/ready event stream carrying the index of the channel being offered.
interface sync_event_arbiter_if
  import sync_evt_pkg::*;
#(
  parameter int N_CH = 4
);
  localparam int CH_W = ch_w(N_CH);

  logic            evt_valid;
  logic [CH_W-1:0] evt_ch;
  logic            evt_ready;

  modport master (output evt_valid, output evt_ch, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, output evt_ready);
endinterface

// File: rtl/sync_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic            gnt_any,
  output logic [CH_W-1:0] gnt_idx
);

  int idx;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sync_event_arbiter.sv
// Serialises per-channel event pulses into one valid/ready stream with drop counting.
//   state   | meaning
//   S_IDLE  | no offer outstanding; pick next pending channel when enabled
//   S_OFFER | evt_valid high, evt_ch held until the consumer accepts
module sync_event_arbiter
  import sync_evt_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          sync_in,
  input  logic                     enable,
  sync_event_arbiter_if.master     evt,
  output logic [N_CH-1:0]          pending,
  input  logic                     drop_clr,
  output logic [N_CH*DROP_W-1:0]   drop_cnt
);

  localparam int CH_W = ch_w(N_CH);

  sync_evt_state_t state_q, state_d;
  logic [N_CH-1:0] prev_q, rise, pend_q, hs_clr;
  logic            valid_q, valid_d, hs;
  logic [CH_W-1:0] ch_q, ch_d, ptr_q, ptr_d, gnt_idx;
  logic            gnt_any;

  assign rise          = sync_in & ~prev_q;
  assign hs_clr        = hs ? (N_CH'(1) << ch_q) : '0;
  assign pending       = pend_q;
  assign evt.evt_valid = valid_q;
  assign evt.evt_ch    = ch_q;

  rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_pick (
    .req     (pend_q),
    .ptr     (ptr_q),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    hs      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && gnt_any) begin
          state_d = S_OFFER;
          valid_d = 1'b1;
          ch_d    = gnt_idx;
        end
      end
      S_OFFER: begin
        if (evt.evt_ready) begin
          hs      = 1'b1;
          state_d = S_IDLE;
          valid_d = 1'b0;
          ptr_d   = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      ch_q    <= '0;
      ptr_q   <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      prev_q  <= sync_in;
      // a rise landing on its own handshake re-arms the flag instead of dropping
      pend_q  <= (pend_q & ~hs_clr) | rise;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_drop
    logic [DROP_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (reset || drop_clr) cnt_q <= '0;
      else if (rise[i] && pend_q[i] && !hs_clr[i] && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
    assign drop_cnt[i*DROP_W +: DROP_W] = cnt_q;
  end

endmodule
